// File: rtl/stoch_decode.sv
// ============================================================================
// Module   : stoch_decode
// Purpose  : Counts ones in a unipolar bitstream over 2^WINDOW_LOG2 enabled
//            samples and presents a saturated estimate via valid/ready.
//            Optional macro STOCH_DECODE_CONT_EN selects continuous windows.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stoch_decode #(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   start,
    input  logic                   clear,
    input  logic                   en,
    input  logic                   bit_in,
    output logic [WINDOW_LOG2-1:0] est,
    output logic                   est_valid,
    input  logic                   est_ready,
    output logic                   busy,
    output logic                   overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [WINDOW_LOG2:0] c_LAST = {1'b0, {WINDOW_LOG2{1'b1}}};

    state_t                 r_state;
    logic [WINDOW_LOG2:0]   r_ones;
    logic [WINDOW_LOG2:0]   r_samples;
    logic [WINDOW_LOG2:0]   w_sum;
    logic [WINDOW_LOG2-1:0] w_sat;
    logic                   w_last;

    // An all-ones window counts 2^WINDOW_LOG2, which does not fit the estimate.
    assign w_sum  = r_ones + {{WINDOW_LOG2{1'b0}}, bit_in};
    assign w_sat  = w_sum[WINDOW_LOG2] ? {WINDOW_LOG2{1'b1}} : w_sum[WINDOW_LOG2-1:0];
    assign w_last = (r_state == S_ACCUM) && en && (r_samples == c_LAST);

`ifdef STOCH_DECODE_CONT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= S_IDLE;
            r_ones    <= '0;
            r_samples <= '0;
            est       <= '0;
            est_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else if (clear) begin
            r_state   <= S_ACCUM;
            r_ones    <= '0;
            r_samples <= '0;
            est_valid <= 1'b0;
            busy      <= 1'b1;
            overrun   <= 1'b0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_last) begin
                        est       <= w_sat;
                        est_valid <= 1'b1;
                        r_ones    <= '0;
                        r_samples <= '0;
                        if (est_valid && !est_ready) begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        if (est_valid && est_ready) begin
                            est_valid <= 1'b0;
                        end
                        if (en) begin
                            r_samples <= r_samples + 1'b1;
                            r_ones    <= w_sum;
                        end
                    end
                end
                default: begin
                    r_state <= S_ACCUM;
                    busy    <= 1'b1;
                end
            endcase
        end
    end
`else
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= S_IDLE;
            r_ones    <= '0;
            r_samples <= '0;
            est       <= '0;
            est_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (clear) begin
            r_state   <= S_IDLE;
            r_ones    <= '0;
            r_samples <= '0;
            est_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ACCUM;
                        busy    <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (w_last) begin
                        est       <= w_sat;
                        est_valid <= 1'b1;
                        r_ones    <= '0;
                        r_samples <= '0;
                        r_state   <= S_HOLD;
                        busy      <= 1'b0;
                    end else if (en) begin
                        r_samples <= r_samples + 1'b1;
                        r_ones    <= w_sum;
                    end
                end
                S_HOLD: begin
                    if (est_ready) begin
                        est_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign overrun = 1'b0;
`endif

endmodule

`default_nettype wire
